codec_config_sequencer: RTL and testbench



---
 rtl/codec_cfg_pkg.sv | 33 +++
 rtl/codec_cfg_rom.sv | 26 ++
 rtl/codec_config_sequencer.sv | 155 +++++++++++++++
 tb/tb_codec_config_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/codec_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : codec_cfg_pkg
// Description : Shared constants for the codec configuration sequencer:
//               FSM state encodings, register-initialisation table, default
//               codec I2C address.
// Revision    : 1.0 - initial release
// ============================================================================
package codec_cfg_pkg;

    localparam int NUM_REGS = 11;

    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h1A;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_SETTLE = 3'd1;
    localparam state_t ST_ISSUE  = 3'd2;
    localparam state_t ST_WAIT   = 3'd3;
    localparam state_t ST_GAP    = 3'd4;
    localparam state_t ST_DONE   = 3'd5;
    localparam state_t ST_ERROR  = 3'd6;

    // Codec register words, written in order. Entry 0 resets the codec and
    // the last entry activates it, so the order must not change.
    localparam logic [15:0] REG_TABLE [NUM_REGS] = '{
        16'h1E00, 16'h0017, 16'h0217, 16'h047F, 16'h067F, 16'h0812,
        16'h0A00, 16'h0C02, 16'h0E23, 16'h1001, 16'h1201
    };

endpackage
`default_nettype wire

// File: rtl/codec_cfg_rom.sv
`default_nettype none
// ============================================================================
// Module      : codec_cfg_rom
// Description : Combinational index -> codec register word lookup. Indices
//               beyond the table return zero.
// Revision    : 1.0 - initial release
// ============================================================================
module codec_cfg_rom
    import codec_cfg_pkg::*;
(
    input  logic [3:0]  index_i,
    output logic [15:0] word_o
);

    // Table lookup; unmatched indices fall through to zero.
    always_comb begin
        word_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (index_i == 4'(i)) begin
                word_o = REG_TABLE[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/codec_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : codec_config_sequencer
// Description : Walks the codec register table and issues one I2C write per
//               entry through a request/done handshake with the byte-level
//               I2C master, retrying on NACK. config_done gates the audio
//               clock domain; error flags retry exhaustion.
// Revision    : 1.0 - initial release
// ============================================================================
module codec_config_sequencer
    import codec_cfg_pkg::*;
#(
    parameter int         STARTUP_DELAY = 1024,
    parameter int         GAP_CYCLES    = 64,
    parameter int         MAX_RETRIES   = 3,
    parameter logic [6:0] DEV_ADDR      = DEFAULT_DEV_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        i2c_req,
    output logic [23:0] i2c_data,
    input  logic        i2c_done,
    input  logic        i2c_ack_ok,
    output logic [3:0]  reg_index,
    output logic [1:0]  retry_count,
    output logic        busy,
    output logic        config_done,
    output logic        error
);

    // One shared delay counter serves both SETTLE and GAP.
    localparam int MAX_DELAY = (STARTUP_DELAY > GAP_CYCLES) ? STARTUP_DELAY : GAP_CYCLES;
    localparam int CNT_W     = (MAX_DELAY < 2) ? 1 : $clog2(MAX_DELAY + 1);

    // Terminal counts: a state lasting N cycles leaves when the count hits N-1.
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((STARTUP_DELAY > 0) ? STARTUP_DELAY - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRIES);
    localparam logic [3:0]       LAST_IDX    = 4'(NUM_REGS - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        idx_q, idx_d;
    logic [1:0]        retry_q, retry_d;
    logic              req_q, req_d;
    logic [23:0]       data_q, data_d;
    logic [15:0]       rom_word;

    codec_cfg_rom u_rom (
        .index_i (idx_q),
        .word_o  (rom_word)
    );

    // Next-state logic for the FSM, counters and request registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        req_d   = req_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_ISSUE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ISSUE: begin
                req_d   = 1'b1;
                data_d  = {DEV_ADDR, 1'b0, rom_word};
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // start is deliberately not looked at here.
                if (i2c_done) begin
                    req_d = 1'b0;
                    cnt_d = '0;
                    if (i2c_ack_ok) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_DONE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            retry_d = '0;
                            state_d = ST_GAP;
                        end
                    end else if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_ISSUE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (start) begin
                    idx_d   = '0;
                    retry_d = '0;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any transfer in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            retry_q <= '0;
            req_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            req_q   <= req_d;
            data_q  <= data_d;
        end
    end

    assign i2c_req     = req_q;
    assign i2c_data    = data_q;
    assign reg_index   = idx_q;
    assign retry_count = retry_q;
    assign busy        = (state_q == ST_SETTLE) || (state_q == ST_ISSUE) ||
                         (state_q == ST_WAIT)   || (state_q == ST_GAP);
    assign config_done = (state_q == ST_DONE);
    assign error       = (state_q == ST_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_codec_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_codec_config_sequencer
// Description : Self-checking bench for codec_config_sequencer. Each
//               transfer is a table record {ack to return, start with done,
//               expected index/retry/data, edges since previous handshake}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_codec_config_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        i2c_req;
    logic [23:0] i2c_data;
    logic        i2c_done;
    logic        i2c_ack_ok;
    logic [3:0]  reg_index;
    logic [1:0]  retry_count;
    logic        busy;
    logic        config_done;
    logic        error;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          ack;
        bit          st;
        logic [3:0]  idx;
        logic [1:0]  retry;
        int          gap;
        logic [23:0] data;
    } vec_t;

    vec_t vecs[$];

    // Expected request words: {7'h1A, write bit 0, register word}.
    logic [23:0] exp_tbl [11] = '{
        24'h341E00, 24'h340017, 24'h340217, 24'h34047F, 24'h34067F, 24'h340812,
        24'h340A00, 24'h340C02, 24'h340E23, 24'h341001, 24'h341201
    };

    codec_config_sequencer #(
        .STARTUP_DELAY (4),
        .GAP_CYCLES    (2),
        .MAX_RETRIES   (3),
        .DEV_ADDR      (7'h1A)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .i2c_req     (i2c_req),
        .i2c_data    (i2c_data),
        .i2c_done    (i2c_done),
        .i2c_ack_ok  (i2c_ack_ok),
        .reg_index   (reg_index),
        .retry_count (retry_count),
        .busy        (busy),
        .config_done (config_done),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req"},   {31'd0, i2c_req},     32'd0);
        check({tag, "_data"},  {8'd0, i2c_data},     32'd0);
        check({tag, "_idx"},   {28'd0, reg_index},   32'd0);
        check({tag, "_retry"}, {30'd0, retry_count}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy},        32'd0);
        check({tag, "_done"},  {31'd0, config_done}, 32'd0);
        check({tag, "_err"},   {31'd0, error},       32'd0);
    endtask

    function automatic vec_t mk(bit ack, bit st, int idx, int retry, int gap);
        vec_t v;
        v.ack   = ack;
        v.st    = st;
        v.idx   = 4'(idx);
        v.retry = 2'(retry);
        v.gap   = gap;
        v.data  = exp_tbl[idx];
        return v;
    endfunction

    // Append ACKed entries first..last; the first one waits first_gap edges.
    task automatic add_run(input int first, input int last, input int first_gap);
        for (int i = first; i <= last; i++) begin
            vecs.push_back(mk(1'b1, 1'b0, i, 0, (i == first) ? first_gap : 3));
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Wait for a request, check it, hold one cycle, then answer it.
    task automatic do_xfer(input vec_t v);
        int k = 0;
        while (i2c_req !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        if (k >= 100) begin
            check("req_timeout", 32'd0, 32'd1);
        end else begin
            check("req_spacing", k, v.gap);
            check("req_data",  {8'd0, i2c_data},     {8'd0, v.data});
            check("req_index", {28'd0, reg_index},   {28'd0, v.idx});
            check("req_retry", {30'd0, retry_count}, {30'd0, v.retry});
            check("req_busy",  {31'd0, busy},        32'd1);
            tick();
            check("hold_req",  {31'd0, i2c_req},     32'd1);
            check("hold_data", {8'd0, i2c_data},     {8'd0, v.data});
            i2c_done   = 1'b1;
            i2c_ack_ok = v.ack;
            start      = v.st;
            tick();
            i2c_done   = 1'b0;
            i2c_ack_ok = 1'b0;
            start      = 1'b0;
            check("req_fall", {31'd0, i2c_req}, 32'd0);
        end
    endtask

    task automatic run_vecs();
        for (int i = 0; i < vecs.size(); i++) begin
            do_xfer(vecs[i]);
        end
        vecs.delete();
    endtask

    task automatic check_done_state(input string tag);
        check({tag, "_cfg_done"}, {31'd0, config_done}, 32'd1);
        check({tag, "_busy"},     {31'd0, busy},        32'd0);
        check({tag, "_err"},      {31'd0, error},       32'd0);
        check({tag, "_idx"},      {28'd0, reg_index},   32'd10);
    endtask

    task automatic check_restart(input string tag);
        check({tag, "_busy"},     {31'd0, busy},        32'd1);
        check({tag, "_cfg_done"}, {31'd0, config_done}, 32'd0);
        check({tag, "_err"},      {31'd0, error},       32'd0);
        check({tag, "_idx"},      {28'd0, reg_index},   32'd0);
        check({tag, "_retry"},    {30'd0, retry_count}, 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        i2c_done   = 1'b0;
        i2c_ack_ok = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();
        tick();
        check_idle_outputs("idle");

        // Nominal run from IDLE.
        pulse_start();
        check("start_busy", {31'd0, busy},    32'd1);
        check("start_req",  {31'd0, i2c_req}, 32'd0);
        add_run(0, 10, 5);
        run_vecs();
        check_done_state("nominal");
        tick();
        tick();
        check("done_sticky", {31'd0, config_done}, 32'd1);

        // Ignored events: start in SETTLE, done in GAP, start with done in WAIT.
        pulse_start();
        check_restart("restart_done");
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        vecs.push_back(mk(1'b1, 1'b0, 0, 0, 3));
        run_vecs();
        i2c_done   = 1'b1;
        i2c_ack_ok = 1'b1;
        tick();
        i2c_done   = 1'b0;
        i2c_ack_ok = 1'b0;
        check("gap_done_idx", {28'd0, reg_index}, 32'd1);
        vecs.push_back(mk(1'b1, 1'b0, 1, 0, 2));
        vecs.push_back(mk(1'b1, 1'b1, 2, 0, 3));
        add_run(3, 10, 3);
        run_vecs();
        check_done_state("ignored");

        // Single NACK on index 3.
        pulse_start();
        add_run(0, 2, 5);
        vecs.push_back(mk(1'b0, 1'b0, 3, 0, 3));
        vecs.push_back(mk(1'b1, 1'b0, 3, 1, 3));
        add_run(4, 10, 3);
        run_vecs();
        check_done_state("nack1");

        // Every attempt on index 5 NACKed.
        pulse_start();
        add_run(0, 4, 5);
        for (int r = 0; r < 4; r++) begin
            vecs.push_back(mk(1'b0, 1'b0, 5, r, 3));
        end
        run_vecs();
        check("exh_err",      {31'd0, error},       32'd1);
        check("exh_busy",     {31'd0, busy},        32'd0);
        check("exh_idx",      {28'd0, reg_index},   32'd5);
        check("exh_cfg_done", {31'd0, config_done}, 32'd0);
        for (int i = 0; i < 6; i++) tick();
        check("exh_no_req",   {31'd0, i2c_req},     32'd0);
        check("exh_sticky",   {31'd0, error},       32'd1);

        // Restart from ERROR with an ACKing master.
        pulse_start();
        check_restart("restart_err");
        add_run(0, 10, 5);
        run_vecs();
        check_done_state("after_err");

        // Reset while waiting on index 6.
        pulse_start();
        add_run(0, 5, 5);
        run_vecs();
        begin
            int k = 0;
            while (i2c_req !== 1'b1 && k < 100) begin
                tick();
                k++;
            end
            check("mid_wait_idx", {28'd0, reg_index}, 32'd6);
        end
        #2;
        reset = 1'b1;
        #1;
        check_idle_outputs("async_rst");
        tick();
        reset = 1'b0;
        tick();
        pulse_start();
        add_run(0, 10, 5);
        run_vecs();
        check_done_state("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
